// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Program-counter sequencer for the IF stage of the pipelined RV32 core.
// It keeps at most one instruction-memory request in flight and advances the
// PC by 4 on every accepted fetch. A one-entry hold buffer covers hazard-unit
// stalls. Branch/jump redirects from EX are accepted at any time after boot,
// including while a request is still outstanding: the stale request is then
// drained and its data discarded.
//
// Optional build macro: PC_MISALIGN_TRAP_EN
//   defined   : a redirect whose target has bits[1:0] != 0 goes to TRAP_VEC,
//               and misalign_o pulses for one cycle (registered).
//   undefined : target bits[1:0] are silently cleared; misalign_o is 0.
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous reset, active low
//   stall_i        in   hazard-unit hold; IF/ID must not accept an instruction
//   redirect_i     in   taken branch/jump from EX (one-cycle pulse)
//   redirect_pc_i  in   redirect target
//   imem_req_o     out  fetch request valid
//   imem_addr_o    out  fetch address, stable while the request waits
//   imem_ready_i   in   request accepted, imem_rdata_i valid this cycle
//   imem_rdata_i   in   fetched instruction
//   if_valid_o     out  if_instr_o / if_pc_o valid for IF/ID this cycle
//   if_instr_o     out  instruction to IF/ID
//   if_pc_o        out  address of if_instr_o
//   pc_o           out  next PC to be fetched
//   misalign_o     out  misaligned-redirect pulse
// -----------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] pc_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        misalign_q, misalign_d;

    logic        redirect_bad;
    logic [31:0] redirect_tgt;
    logic [31:0] pc_inc;

    // A misaligned target only traps when the feature is built in; otherwise
    // the low two bits are simply dropped so the PC stays word aligned.
    assign redirect_bad = TrapEn && (redirect_pc_i[1:0] != 2'b00);
    assign redirect_tgt = redirect_bad ? TRAP_VEC : {redirect_pc_i[31:2], 2'b00};

    // Natural 32-bit wrap: 0xFFFF_FFFC + 4 = 0x0000_0000.
    assign pc_inc = pc_q + 32'd4;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        misalign_d   = 1'b0;

        imem_req_o   = 1'b0;
        imem_addr_o  = 32'h0000_0000;
        if_valid_o   = 1'b0;
        if_instr_o   = 32'h0000_0000;
        if_pc_o      = 32'h0000_0000;

        unique case (state_q)
            ST_BOOT: begin
                // One idle cycle after reset release before the first request.
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                imem_req_o  = 1'b1;
                imem_addr_o = pc_q;
                // Remember the address in flight so a redirect can drain it.
                req_addr_d  = pc_q;

                if (redirect_i) begin
                    pc_d       = redirect_tgt;
                    misalign_d = redirect_bad;
                    // Accepted this cycle: response is simply dropped.
                    // Not accepted: the memory still owes us a beat.
                    if (!imem_ready_i) begin
                        state_d = ST_DRAIN;
                    end
                end else if (imem_ready_i) begin
                    pc_d = pc_inc;
                    if (stall_i) begin
                        hold_instr_d = imem_rdata_i;
                        hold_pc_d    = pc_q;
                        state_d      = ST_HOLD;
                    end else begin
                        if_valid_o = 1'b1;
                        if_instr_o = imem_rdata_i;
                        if_pc_o    = pc_q;
                    end
                end
            end

            ST_HOLD: begin
                if (redirect_i) begin
                    pc_d         = redirect_tgt;
                    misalign_d   = redirect_bad;
                    hold_instr_d = 32'h0000_0000;
                    hold_pc_d    = 32'h0000_0000;
                    state_d      = ST_FETCH;
                end else if (!stall_i) begin
                    if_valid_o   = 1'b1;
                    if_instr_o   = hold_instr_q;
                    if_pc_o      = hold_pc_q;
                    hold_instr_d = 32'h0000_0000;
                    hold_pc_d    = 32'h0000_0000;
                    state_d      = ST_FETCH;
                end
            end

            ST_DRAIN: begin
                // Keep presenting the stale address until the memory accepts
                // it; the returned data belongs to the abandoned path.
                imem_req_o  = 1'b1;
                imem_addr_o = req_addr_q;
                if (redirect_i) begin
                    pc_d       = redirect_tgt;
                    misalign_d = redirect_bad;
                end
                if (imem_ready_i) begin
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_VEC;
            req_addr_q   <= 32'h0000_0000;
            hold_instr_q <= 32'h0000_0000;
            hold_pc_q    <= 32'h0000_0000;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            misalign_q   <= misalign_d;
        end
    end

    assign pc_o       = pc_q;
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
`timescale 1ns/1ps
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
`ifdef PC_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic [31:0] pc_o;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_rdata_i = mem_word(imem_addr_o);

    pc_fetch_ctrl #(
        .RESET_VEC(RESET_VEC),
        .TRAP_VEC (TRAP_VEC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ready_i (imem_ready_i),
        .imem_rdata_i (imem_rdata_i),
        .if_valid_o   (if_valid_o),
        .if_instr_o   (if_instr_o),
        .if_pc_o      (if_pc_o),
        .pc_o         (pc_o),
        .misalign_o   (misalign_o)
    );

    task automatic drive(input logic st, input logic rd, input logic [31:0] tgt, input logic rdy);
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = tgt;
        imem_ready_i  = rdy;
    endtask

    // Leaves the bench at a falling edge with the DUT in its first fetch cycle.
    task automatic do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req_o); end
        checks++; if (pc_o !== RESET_VEC) begin errors++; $display("FAIL rst_pc got %h exp %h", pc_o, RESET_VEC); end
        checks++; if (if_valid_o !== 1'b0 || if_instr_o !== 32'h0 || if_pc_o !== 32'h0) begin errors++; $display("FAIL rst_if got v=%b i=%h p=%h exp all 0", if_valid_o, if_instr_o, if_pc_o); end
        checks++; if (imem_addr_o !== 32'h0 || misalign_o !== 1'b0) begin errors++; $display("FAIL rst_misc got addr=%h mis=%b exp 0", imem_addr_o, misalign_o); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL boot_req got %b exp 0", imem_req_o); end
        @(negedge clk);
        #1;
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_VEC) begin errors++; $display("FAIL first_req got req=%b addr=%h exp 1 %h", imem_req_o, imem_addr_o, RESET_VEC); end
        // Reset while the request is outstanding must drop it at once.
        #2;
        rst = 1'b0;
        #1;
        checks++; if (imem_req_o !== 1'b0 || pc_o !== RESET_VEC) begin errors++; $display("FAIL midreq_rst got req=%b pc=%h exp 0 %h", imem_req_o, pc_o, RESET_VEC); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            #1;
            checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr%0d got req=%b addr=%h exp 1 %h", i, imem_req_o, imem_addr_o, 32'(4 * i)); end
            checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'(4 * i) || if_instr_o !== mem_word(32'(4 * i))) begin errors++; $display("FAIL seq_if%0d got v=%b pc=%h i=%h exp 1 %h %h", i, if_valid_o, if_pc_o, if_instr_o, 32'(4 * i), mem_word(32'(4 * i))); end
            @(negedge clk);
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            @(negedge clk);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        #1;
        checks++; if (imem_addr_o !== 32'h8 || if_valid_o !== 1'b0) begin errors++; $display("FAIL stall_capture got addr=%h v=%b exp 8 0", imem_addr_o, if_valid_o); end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive((i < 2) ? 1'b1 : 1'b0, 1'b0, 32'h0, 1'b0);
            #1;
            checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL hold_req%0d got %b exp 0", i, imem_req_o); end
            if (i < 2) begin
                checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL hold_valid%0d got %b exp 0", i, if_valid_o); end
            end else begin
                checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h8 || if_instr_o !== mem_word(32'h8)) begin errors++; $display("FAIL hold_release got v=%b pc=%h i=%h exp 1 8 %h", if_valid_o, if_pc_o, if_instr_o, mem_word(32'h8)); end
            end
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hC) begin errors++; $display("FAIL after_hold got req=%b addr=%h exp 1 c", imem_req_o, imem_addr_o); end
        @(negedge clk);
    endtask

    task automatic test_redirect_outstanding();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        checks++; if (imem_addr_o !== 32'h10) begin errors++; $display("FAIL drain_issue got %h exp 10", imem_addr_o); end
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h200, 1'b0);
        #1;
        checks++; if (imem_addr_o !== 32'h10 || if_valid_o !== 1'b0) begin errors++; $display("FAIL drain_redir got addr=%h v=%b exp 10 0", imem_addr_o, if_valid_o); end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10 || pc_o !== 32'h200) begin errors++; $display("FAIL drain_wait got req=%b addr=%h pc=%h exp 1 10 200", imem_req_o, imem_addr_o, pc_o); end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        checks++; if (imem_addr_o !== 32'h10 || if_valid_o !== 1'b0) begin errors++; $display("FAIL drain_discard got addr=%h v=%b exp 10 0", imem_addr_o, if_valid_o); end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        checks++; if (imem_addr_o !== 32'h200 || if_valid_o !== 1'b1 || if_pc_o !== 32'h200) begin errors++; $display("FAIL drain_target got addr=%h v=%b pc=%h exp 200 1 200", imem_addr_o, if_valid_o, if_pc_o); end
        @(negedge clk);
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            @(negedge clk);
        end
        drive(1'b0, 1'b1, 32'h400, 1'b1);
        #1;
        checks++; if (imem_addr_o !== 32'h14 || if_valid_o !== 1'b0) begin errors++; $display("FAIL same_redir got addr=%h v=%b exp 14 0", imem_addr_o, if_valid_o); end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        checks++; if (imem_addr_o !== 32'h400 || if_pc_o !== 32'h400) begin errors++; $display("FAIL same_next got addr=%h pc=%h exp 400 400", imem_addr_o, if_pc_o); end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        checks++; if (imem_addr_o !== 32'hFFFF_FFFC || if_pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top got addr=%h pc=%h exp fffffffc", imem_addr_o, if_pc_o); end
        @(negedge clk);
        #1;
        checks++; if (imem_addr_o !== 32'h0 || pc_o !== 32'h0) begin errors++; $display("FAIL wrap_zero got addr=%h pc=%h exp 0", imem_addr_o, pc_o); end
        @(negedge clk);
    endtask

    task automatic test_misalign();
        logic [31:0] exp_a;
        do_reset();
        drive(1'b0, 1'b1, 32'h0000_0102, 1'b1);
        #1;
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_same got %b exp 0", misalign_o); end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        checks++; if (imem_addr_o !== 32'h100) begin errors++; $display("FAIL mis_addr got %h exp 100", imem_addr_o); end
        checks++; if (misalign_o !== MIS_EN) begin errors++; $display("FAIL mis_pulse got %b exp %b", misalign_o, MIS_EN); end
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h0000_0203, 1'b1);
        #1;
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_clear got %b exp 0", misalign_o); end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        exp_a = MIS_EN ? TRAP_VEC : 32'h200;
        #1;
        checks++; if (imem_addr_o !== exp_a || misalign_o !== MIS_EN) begin errors++; $display("FAIL mis_203 got addr=%h mis=%b exp %h %b", imem_addr_o, misalign_o, exp_a, MIS_EN); end
        @(negedge clk);
    endtask

    // Randomized run against a transaction-level model: where the next new
    // fetch goes, whether a stale beat is owed, and what sits in the buffer.
    task automatic test_random();
        logic [31:0] m_pc, m_stale_addr, m_held_pc, eff, e_addr, e_vpc, tgt;
        logic        m_stale, m_held, m_mis, e_req, e_valid, rdy, st, rd, bad;
        int          lat;
        do_reset();
        m_pc = RESET_VEC; m_stale = 0; m_held = 0; m_mis = 0;
        m_stale_addr = 0; m_held_pc = 0; lat = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            e_req  = !m_held;
            e_addr = m_stale ? m_stale_addr : m_pc;
            rdy    = e_req && (lat == 0);
            st     = ($urandom_range(0, 3) == 0);
            rd     = ($urandom_range(0, 7) == 0);
            tgt    = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : ($urandom & 32'h0000_3FFF);
            drive(st, rd, tgt, rdy);
            #1;
            bad = MIS_EN && (tgt[1:0] != 2'b00);
            eff = bad ? TRAP_VEC : {tgt[31:2], 2'b00};
            e_valid = 1'b0; e_vpc = 32'h0;
            checks++; if (imem_req_o !== e_req || (e_req && imem_addr_o !== e_addr)) begin errors++; $display("FAIL rnd_req c%0d got req=%b addr=%h exp %b %h", cyc, imem_req_o, imem_addr_o, e_req, e_addr); end
            checks++; if (pc_o !== m_pc) begin errors++; $display("FAIL rnd_pc c%0d got %h exp %h", cyc, pc_o, m_pc); end
            checks++; if (misalign_o !== m_mis) begin errors++; $display("FAIL rnd_mis c%0d got %b exp %b", cyc, misalign_o, m_mis); end
            if (m_held) begin
                if (rd) begin
                    m_pc = eff; m_held = 0;
                end else if (!st) begin
                    e_valid = 1; e_vpc = m_held_pc; m_held = 0;
                end
            end else if (m_stale) begin
                if (rd) m_pc = eff;
                if (rdy) m_stale = 0;
            end else if (rd) begin
                if (!rdy) begin m_stale = 1; m_stale_addr = m_pc; end
                m_pc = eff;
            end else if (rdy) begin
                if (st) begin m_held = 1; m_held_pc = m_pc; end
                else begin e_valid = 1; e_vpc = m_pc; end
                m_pc = m_pc + 32'd4;
            end
            checks++; if (if_valid_o !== e_valid || (e_valid && (if_pc_o !== e_vpc || if_instr_o !== mem_word(e_vpc)))) begin errors++; $display("FAIL rnd_if c%0d got v=%b pc=%h i=%h exp %b %h %h", cyc, if_valid_o, if_pc_o, if_instr_o, e_valid, e_vpc, mem_word(e_vpc)); end
            m_mis = rd && bad;
            if (rdy) lat = $urandom_range(0, 3);
            else if (e_req && lat > 0) lat--;
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall_hold();
        test_redirect_outstanding();
        test_redirect_same_cycle();
        test_wrap();
        test_misalign();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Sequences the program counter for the IF stage of the pipelined RV32 core.
- Issues one instruction-memory request at a time and advances PC by 4 on each accepted fetch.
- Handles hazard-unit stalls with a one-entry hold buffer, and branch/jump redirects from EX, including redirects that arrive while a request is still outstanding.
- Feeds the IF/ID pipeline register.

Parameters:
- RESET_VEC, 32'h0000_0000: first fetch address after reset.
- TRAP_VEC, 32'h0000_0100: redirect target on a misaligned redirect. Used only with PC_MISALIGN_TRAP_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- stall_i  in  1  hazard-unit hold; IF/ID must not accept an instruction.
- redirect_i  in  1  taken branch/jump from EX, one-cycle pulse.
- redirect_pc_i  in  32  redirect target.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  32  fetch address; stable while imem_req_o=1 and imem_ready_i=0.
- imem_ready_i  in  1  request accepted and imem_rdata_i valid in the same cycle.
- imem_rdata_i  in  32  fetched instruction.
- if_valid_o  out  1  if_instr_o / if_pc_o valid for IF/ID this cycle.
- if_instr_o  out  32  instruction to IF/ID.
- if_pc_o  out  32  address of if_instr_o.
- pc_o  out  32  next PC to be fetched (pc_q).
- misalign_o  out  1  misaligned-redirect pulse. Tied 0 without PC_MISALIGN_TRAP_EN.

Behaviour:
- Reset (rst=0, asynchronous):
  - State=BOOT; pc_q=RESET_VEC; req_addr_q=0; hold buffer cleared.
  - All outputs 0, except pc_o=RESET_VEC.
  - Reset mid-request abandons the request. The memory shares this reset.
- States: BOOT, FETCH, HOLD, DRAIN.
- BOOT:
  - imem_req_o=0.
  - Next cycle -> FETCH.
- FETCH:
  - imem_req_o=1; imem_addr_o=pc_q. req_addr_q tracks pc_q.
  - Priority: redirect_i > imem_ready_i > stall_i.
- FETCH with redirect_i=1:
  - pc_q <= target.
  - If imem_ready_i=1 the same cycle, the response is dropped (if_valid_o=0) and state stays FETCH.
  - If imem_ready_i=0, go to DRAIN with req_addr_q frozen.
- FETCH with imem_ready_i=1, no redirect, stall_i=0:
  - if_valid_o=1, if_instr_o=imem_rdata_i, if_pc_o=pc_q (combinational pass-through).
  - pc_q <= pc_q+4.
- FETCH with imem_ready_i=1, no redirect, stall_i=1:
  - Capture rdata and pc_q into the hold buffer.
  - pc_q <= pc_q+4; go to HOLD; if_valid_o=0.
- FETCH with imem_ready_i=0: keep requesting the same address. Stall has no effect.
- HOLD:
  - imem_req_o=0.
  - redirect_i=1: clear the buffer, pc_q <= target, go to FETCH.
  - Else stall_i=0: if_valid_o=1 with the buffered instruction and pc, then go to FETCH.
  - Else: stay in HOLD.
- DRAIN:
  - imem_req_o=1; imem_addr_o=req_addr_q (the stale address).
  - On imem_ready_i=1: discard the data (if_valid_o=0) and go to FETCH at pc_q.
  - A further redirect during DRAIN overwrites pc_q; the latest redirect wins.
- Latency: a fetch completing in cycle N is presented in cycle N. The first request is issued in the cycle after reset release +1 (BOOT).
- Arithmetic: pc_q+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Redirect target without the feature: redirect_pc_i with bits[1:0] forced to 2'b00.
- if_valid_o is never asserted in a cycle where redirect_i=1.
- if_valid_o is never asserted while stall_i=1.

Optional Feature:
- PC_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_pc_i[1:0]!=0 sets pc_q <= TRAP_VEC instead of the target.
  - misalign_o=1 for exactly that cycle (registered, visible the next cycle).
- Undefined:
  - misalign_o is constant 0.
  - Bits[1:0] of the target are silently cleared.

Test Plan:
- Reset release, memory with ready always 1, no stall -> imem_addr_o 0x0, 0x4, 0x8; if_valid_o=1 each cycle from the 2nd cycle post-reset; if_pc_o matches.
- stall_i=1 for 3 cycles coinciding with a ready at 0x8 -> HOLD; imem_req_o=0 for 3 cycles. After release: if_instr_o=data@0x8, if_pc_o=0x8, then fetch at 0xC.
- Memory ready latency 3, redirect_i to 0x200 one cycle after the request at 0x10 -> imem_addr_o stays 0x10 until ready; that data is not presented; the next request is 0x200.
- Redirect to 0x400 in the same cycle as ready for 0x14 -> if_valid_o=0 that cycle; next imem_addr_o=0x400.
- pc_q=0xFFFF_FFFC, ready=1 -> next imem_addr_o=0x0000_0000.
- With PC_MISALIGN_TRAP_EN, redirect to 0x0000_0102 -> misalign_o pulse; next fetch 0x0000_0100. Without the macro -> next fetch 0x0000_0100 via masking, misalign_o=0.
